// File: rtl/multi_channel_countdown_timer.sv
// NUM_CH independent countdown channels that share one prescaled tick.
// Each channel supports load, pause, one-shot or auto-reload mode, and a sticky done flag.
module multi_channel_countdown_timer #(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int TICK_HZ     = 1,
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_CH-1:0]       load,
    input  logic [NUM_CH*CNT_W-1:0] load_value,
    input  logic [NUM_CH-1:0]       pause,
    input  logic [NUM_CH-1:0]       auto_reload,
    output logic [NUM_CH*CNT_W-1:0] current_time,
    output logic [NUM_CH-1:0]       running,
    output logic [NUM_CH-1:0]       done,
    output logic [NUM_CH-1:0]       done_pulse,
    output logic                    tick
);

    localparam int              DIV    = CLK_FREQ_HZ / TICK_HZ;
    localparam int              PS_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PS_W-1:0] PS_MAX = PS_W'(DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_PAUSED  = 2'd2,
        ST_EXPIRED = 2'd3
    } state_e;

    typedef struct packed {
        state_e           state;
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] reload;
        logic             mode;
        logic             done;
        logic             pulse;
        logic             running;
    } ch_t;

    logic [PS_W-1:0] ps_q, ps_d;
    logic            tick_q, tick_d;
    ch_t             ch_q [NUM_CH];
    ch_t             ch_d [NUM_CH];

    always_comb begin
        tick_d = (ps_q == PS_MAX);
        ps_d   = tick_d ? '0 : ps_q + PS_W'(1);
    end

    // Each channel acts on the registered tick. A load overrides a pause, and a pause overrides a tick.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            // NOTE: every field is given a default from the held state first, so no path can infer a latch.
            ch_d[i]       = ch_q[i];
            ch_d[i].pulse = 1'b0;
            if (load[i]) begin
                ch_d[i].cnt    = load_value[i*CNT_W +: CNT_W];
                ch_d[i].reload = load_value[i*CNT_W +: CNT_W];
                ch_d[i].mode   = auto_reload[i];
                ch_d[i].done   = 1'b0;
                if (load_value[i*CNT_W +: CNT_W] == '0) begin
                    ch_d[i].state = ST_IDLE;
                end else if (pause[i]) begin
                    ch_d[i].state = ST_PAUSED;
                end else begin
                    ch_d[i].state = ST_RUN;
                end
            end else begin
                case (ch_q[i].state)
                    ST_RUN: begin
                        if (pause[i]) begin
                            ch_d[i].state = ST_PAUSED;
                        end else if (tick_q) begin
                            if (ch_q[i].cnt > CNT_W'(1)) begin
                                ch_d[i].cnt = ch_q[i].cnt - CNT_W'(1);
                            end else begin
                                ch_d[i].pulse = 1'b1;
                                ch_d[i].done  = 1'b1;
                                if (ch_q[i].mode) begin
                                    ch_d[i].cnt = ch_q[i].reload;
                                end else begin
                                    ch_d[i].cnt   = '0;
                                    ch_d[i].state = ST_EXPIRED;
                                end
                            end
                        end
                    end
                    ST_PAUSED: begin
                        if (!pause[i]) begin
                            ch_d[i].state = ST_RUN;
                        end
                    end
                    default: begin
                    end
                endcase
            end
            ch_d[i].running = (ch_d[i].state == ST_RUN);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ps_q   <= '0;
            tick_q <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                ch_q[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments let every flop sample the values from before this edge.
            ps_q   <= ps_d;
            tick_q <= tick_d;
            for (int i = 0; i < NUM_CH; i++) begin
                ch_q[i] <= ch_d[i];
            end
        end
    end

    always_comb begin
        current_time = '0;
        running      = '0;
        done         = '0;
        done_pulse   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            current_time[i*CNT_W +: CNT_W] = ch_q[i].cnt;
            running[i]                     = ch_q[i].running;
            done[i]                        = ch_q[i].done;
            done_pulse[i]                  = ch_q[i].pulse;
        end
    end

    assign tick = tick_q;

endmodule

// File: tb/tb_multi_channel_countdown_timer.sv
// Randomised and directed stimulus for the multi-channel countdown timer.
// A behavioural model feeds a scoreboard, and a separate monitor compares the DUT against it every cycle.
module tb_multi_channel_countdown_timer;

    localparam int CLK_FREQ_HZ = 10;
    localparam int TICK_HZ     = 1;
    localparam int DIV         = CLK_FREQ_HZ / TICK_HZ;
    localparam int NUM_CH      = 4;
    localparam int CNT_W       = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  load = '0;
    logic [31:0] load_value = '0;
    logic [3:0]  pause = '0;
    logic [3:0]  auto_reload = '0;
    logic [31:0] current_time;
    logic [3:0]  running;
    logic [3:0]  done;
    logic [3:0]  done_pulse;
    logic        tick;

    multi_channel_countdown_timer #(
        .CLK_FREQ_HZ(CLK_FREQ_HZ),
        .TICK_HZ    (TICK_HZ),
        .NUM_CH     (NUM_CH),
        .CNT_W      (CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (load),
        .load_value  (load_value),
        .pause       (pause),
        .auto_reload (auto_reload),
        .current_time(current_time),
        .running     (running),
        .done        (done),
        .done_pulse  (done_pulse),
        .tick        (tick)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] cur;
        logic [3:0]  running;
        logic [3:0]  done;
        logic [3:0]  pulse;
        logic        tick;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   started  = 0;

    // Model: a channel is armed while it still has a count to run out. While it is held by pause, it ignores ticks.
    int m_cnt   [NUM_CH];
    int m_rel   [NUM_CH];
    bit m_auto  [NUM_CH];
    bit m_done  [NUM_CH];
    bit m_armed [NUM_CH];
    bit m_held  [NUM_CH];
    bit m_pulse [NUM_CH];
    int m_edges;
    bit m_tick;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NUM_CH; i++) begin
            m_cnt[i] = 0; m_rel[i] = 0; m_auto[i] = 0; m_done[i] = 0;
            m_armed[i] = 0; m_held[i] = 0; m_pulse[i] = 0;
        end
        m_edges = 0;
        m_tick  = 0;
    endtask

    task automatic step(input bit rst, input logic [3:0] ld, input logic [31:0] lv,
                        input logic [3:0] ps, input logic [3:0] ar);
        exp_t e;
        @(negedge clk);
        rst_n = rst; load = ld; load_value = lv; pause = ps; auto_reload = ar;
        if (!rst) begin
            model_reset();
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                int v;
                v = int'(lv[i*8 +: 8]);
                m_pulse[i] = 0;
                if (ld[i]) begin
                    m_cnt[i] = v; m_rel[i] = v; m_auto[i] = ar[i]; m_done[i] = 0;
                    m_armed[i] = (v != 0);
                    m_held[i]  = (v != 0) && ps[i];
                end else if (m_armed[i]) begin
                    if (m_held[i]) begin
                        m_held[i] = ps[i];
                    end else if (ps[i]) begin
                        m_held[i] = 1;
                    end else if (m_tick) begin
                        if (m_cnt[i] == 1) begin
                            m_pulse[i] = 1;
                            m_done[i]  = 1;
                            if (m_auto[i]) begin
                                m_cnt[i] = m_rel[i];
                            end else begin
                                m_cnt[i]   = 0;
                                m_armed[i] = 0;
                            end
                        end else begin
                            m_cnt[i] = m_cnt[i] - 1;
                        end
                    end
                end
            end
            m_edges++;
            m_tick = (m_edges % DIV == 0);
        end
        for (int i = 0; i < NUM_CH; i++) begin
            e.cur[i*8 +: 8] = 8'(m_cnt[i]);
            e.running[i]    = m_armed[i] && !m_held[i];
            e.done[i]       = m_done[i];
            e.pulse[i]      = m_pulse[i];
        end
        e.tick = m_tick;
        sb_q.push_back(e);
        started = 1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1, '0, '0, '0, '0);
    endtask

    task automatic wait_tick();
        for (int k = 0; k < DIV && !m_tick; k++) idle(1);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (started) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL scoreboard_underflow at %0t: got 0 entries expected 1", $time);
                end else begin
                    e = sb_q.pop_front();
                    check("current_time", current_time, e.cur);
                    check("running", {28'd0, running}, {28'd0, e.running});
                    check("done", {28'd0, done}, {28'd0, e.done});
                    check("done_pulse", {28'd0, done_pulse}, {28'd0, e.pulse});
                    check("tick", {31'd0, tick}, {31'd0, e.tick});
                end
            end
        end
    end

    initial begin
        logic [3:0]  rnd_ps;
        logic [3:0]  rnd_ld;
        logic [3:0]  rnd_ar;
        logic [31:0] rnd_lv;
        model_reset();
        step(0, '0, '0, '0, '0);
        step(0, '0, '0, '0, '0);
        step(1, '0, '0, '0, '0);
        idle(25);

        step(1, 4'b0001, 32'h0000_0003, '0, '0);
        idle(45);

        step(1, 4'b0010, 32'h0000_0200, '0, 4'b0010);
        idle(60);

        step(1, 4'b0100, 32'h0005_0000, '0, '0);
        for (int k = 0; k < 50 && m_cnt[2] != 3; k++) idle(1);
        for (int k = 0; k < 30; k++) step(1, '0, '0, 4'b0100, '0);
        idle(40);

        step(1, 4'b0100, 32'h0005_0000, '0, '0);
        wait_tick();
        for (int k = 0; k < 5; k++) step(1, '0, '0, 4'b0100, '0);
        idle(60);

        wait_tick();
        step(1, 4'b1000, 32'h0400_0000, '0, '0);
        idle(15);
        step(1, 4'b1000, 32'h0900_0000, '0, '0);
        idle(100);
        step(1, 4'b1000, 32'h0900_0000, '0, '0);
        idle(15);
        step(1, 4'b1000, 32'h0000_0000, '0, '0);
        idle(15);

        step(1, 4'b0001, 32'h0000_0002, 4'b0001, '0);
        for (int k = 0; k < 12; k++) step(1, '0, '0, 4'b0001, '0);
        idle(30);

        step(1, 4'b0001, 32'h0000_00ff, '0, '0);
        idle(2560);

        step(1, 4'b1111, 32'h0609_0807, '0, 4'b0101);
        idle(23);
        step(0, '0, '0, '0, '0);
        #1;
        check("rst_current_time", current_time, 32'd0);
        check("rst_running", {28'd0, running}, 32'd0);
        check("rst_done", {28'd0, done}, 32'd0);
        check("rst_tick", {31'd0, tick}, 32'd0);
        step(0, '0, '0, '0, '0);
        step(1, '0, '0, '0, '0);
        idle(25);

        rnd_ps = '0;
        for (int c = 0; c < 3000; c++) begin
            rnd_ld = '0;
            rnd_lv = '0;
            rnd_ar = 4'($urandom_range(0, 15));
            for (int i = 0; i < NUM_CH; i++) begin
                int r;
                if ($urandom_range(0, 39) == 0) rnd_ld[i] = 1'b1;
                if ($urandom_range(0, 19) == 0) rnd_ps[i] = ~rnd_ps[i];
                r = int'($urandom_range(0, 9));
                if (r == 0)      rnd_lv[i*8 +: 8] = 8'd0;
                else if (r == 9) rnd_lv[i*8 +: 8] = 8'(200 + $urandom_range(0, 55));
                else             rnd_lv[i*8 +: 8] = 8'($urandom_range(1, 6));
            end
            step(1, rnd_ld, rnd_lv, rnd_ps, rnd_ar);
        end
        idle(2);

        @(posedge clk);
        #2;
        check("scoreboard_drained", sb_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
